// File: rtl/bram_arbiter.sv
// bram_arbiter
// Shares one single-port synchronous block RAM between the 6502 core (m0)
// and the UART debug/loader engine (m1). One access is granted per cycle with
// zero grant latency. m0 has priority, but after MAX_BURST consecutive m0
// grants with m1 waiting, m1 gets the next slot. m1 can take exclusive
// ownership of the RAM with m1_lock for atomic multi-cycle sequences.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   m0_*/m1_*  (in)         req, we, addr, wdata per requester; m1_lock
//   m0_gnt, m1_gnt (out)    combinational grant, at most one high
//   m0/m1_rvalid, _rdata    registered read-return, one cycle after grant
//   mem_en/we/addr/wdata    RAM control, muxed from the granted port
//   mem_rdata  (in)         RAM output, one cycle after mem_en
module bram_arbiter #(
    parameter int AW        = 13,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

    logic [3:0] r_wait_cnt;
    logic       r_lock_q;
    logic [1:0] r_rd_owner;

    logic       w_locked;
    logic       w_m0_gnt;
    logic       w_m1_gnt;

    // The lock only holds while m1 keeps m1_lock high; dropping it hands
    // control back to normal arbitration in the same cycle.
    assign w_locked = r_lock_q & m1_lock;

    always_comb begin
        w_m0_gnt = 1'b0;
        w_m1_gnt = 1'b0;
        if (!reset) begin
            if (w_locked) begin
                w_m1_gnt = m1_req;
            end else if (m0_req && m1_req) begin
                if (r_wait_cnt < LP_MAX) begin
                    w_m0_gnt = 1'b1;
                end else begin
                    w_m1_gnt = 1'b1;
                end
            end else begin
                w_m0_gnt = m0_req;
                w_m1_gnt = m1_req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
            r_lock_q   <= 1'b0;
            r_rd_owner <= 2'b00;
        end else begin
            if (w_m1_gnt || !m1_req) begin
                r_wait_cnt <= 4'd0;
            end else if (w_m0_gnt && r_wait_cnt < LP_MAX) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            r_lock_q   <= m1_lock & (r_lock_q | w_m1_gnt);
            r_rd_owner <= {w_m1_gnt & ~m1_we, w_m0_gnt & ~m0_we};
        end
    end

    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign mem_en    = w_m0_gnt | w_m1_gnt;
    // Idle cycles park the address/data mux on m0 and force we low.
    assign mem_we    = w_m1_gnt ? m1_we : (w_m0_gnt & m0_we);
    assign mem_addr  = w_m1_gnt ? m1_addr  : m0_addr;
    assign mem_wdata = w_m1_gnt ? m1_wdata : m0_wdata;

    assign m0_rvalid = r_rd_owner[0];
    assign m1_rvalid = r_rd_owner[1];
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter
// Directed bench for bram_arbiter with a behavioural single-port RAM behind it.
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// further unit later, well before the next edge.
module tb_bram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    bram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
        repeat (2) tick();

        // held in reset with both requesting: everything gated low
        m0_req = 1; m1_req = 1;
        #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        reset = 0;
        #1;
        chk("first_gnt_m0", m0_gnt, 1);
        chk("first_gnt_m1", m1_gnt, 0);
        m0_req = 0; m1_req = 0;

        // m0 alone: write 0x0123 <- A5, then read it back
        tick();
        m0_req = 1; m0_we = 1; m0_addr = 13'h0123; m0_wdata = 8'hA5;
        #1;
        chk("wr_gnt", m0_gnt, 1);
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 13'h0123);
        chk("wr_mem_wdata", mem_wdata, 8'hA5);
        tick();
        m0_we = 0;
        #1;
        chk("rd_gnt", m0_gnt, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("wr_no_rvalid", m0_rvalid, 0);
        tick();
        m0_req = 0;
        #1;
        chk("rd_m0_rvalid", m0_rvalid, 1);
        chk("rd_m0_rdata", m0_rdata, 8'hA5);
        chk("rd_m1_rvalid", m1_rvalid, 0);
        tick();
        #1;
        chk("rd_rvalid_one_cycle", m0_rvalid, 0);
        chk("idle_mem_en", mem_en, 0);

        // preload test patterns through m0
        m0_req = 1; m0_we = 1;
        m0_addr = 13'h0001; m0_wdata = 8'h11; tick();
        m0_addr = 13'h0002; m0_wdata = 8'h22; tick();
        m0_addr = 13'h0010; m0_wdata = 8'h5A; tick();
        m0_req = 0; m0_we = 0;
        tick();

        // both requesting writes continuously: m0 x4 then m1, repeating
        m0_req = 1; m0_we = 1; m0_addr = 13'h1F00;
        m1_req = 1; m1_we = 1; m1_addr = 13'h1F01;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("burst_m0_gnt[%0d]", k), m0_gnt, (k % 5) != 4);
            chk($sformatf("burst_m1_gnt[%0d]", k), m1_gnt, (k % 5) == 4);
            chk($sformatf("burst_addr[%0d]", k), mem_addr, ((k % 5) == 4) ? 13'h1F01 : 13'h1F00);
            chk($sformatf("burst_wcnt[%0d]", k), dut.r_wait_cnt, k % 5);
            tick();
        end
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        tick();

        // m1 locked reads of 0x0010 while m0 requests
        m1_req = 1; m1_addr = 13'h0010; m1_lock = 1;
        #1;
        chk("lk0_m1_gnt", m1_gnt, 1);
        chk("lk0_m0_gnt", m0_gnt, 0);
        tick();
        m0_req = 1; m0_addr = 13'h0001;
        #1;
        chk("lk1_m1_gnt", m1_gnt, 1);
        chk("lk1_m0_gnt", m0_gnt, 0);
        chk("lk1_m1_rvalid", m1_rvalid, 1);
        chk("lk1_m1_rdata", m1_rdata, 8'h5A);
        tick();
        #1;
        chk("lk2_m1_gnt", m1_gnt, 1);
        chk("lk2_m0_gnt", m0_gnt, 0);
        tick();
        m1_req = 0;
        #1;
        chk("lk_idle_m0_gnt", m0_gnt, 0);
        chk("lk_idle_mem_en", mem_en, 0);
        chk("lk_idle_m1_rvalid", m1_rvalid, 1);
        tick();
        m1_lock = 0;
        #1;
        chk("unlk_m0_gnt", m0_gnt, 1);
        chk("unlk_wcnt", dut.r_wait_cnt, 0);
        chk("unlk_m1_rvalid", m1_rvalid, 0);
        tick();
        m0_req = 0;
        #1;
        chk("unlk_m0_rvalid", m0_rvalid, 1);
        chk("unlk_m0_rdata", m0_rdata, 8'h11);

        // alternating back-to-back reads
        tick();
        m0_req = 1; m0_addr = 13'h0001;
        #1;
        chk("alt_m0_gnt", m0_gnt, 1);
        tick();
        m0_req = 0; m1_req = 1; m1_addr = 13'h0002;
        #1;
        chk("alt_m1_gnt", m1_gnt, 1);
        chk("alt_n1_m0_rvalid", m0_rvalid, 1);
        chk("alt_n1_m0_rdata", m0_rdata, 8'h11);
        chk("alt_n1_m1_rvalid", m1_rvalid, 0);
        tick();
        m1_req = 0;
        #1;
        chk("alt_n2_m1_rvalid", m1_rvalid, 1);
        chk("alt_n2_m1_rdata", m1_rdata, 8'h22);
        chk("alt_n2_m0_rvalid", m0_rvalid, 0);

        // reset in the cycle after a locked m1 read grant
        tick();
        m1_req = 1; m1_addr = 13'h0002; m1_lock = 1;
        #1;
        chk("rlk_m1_gnt", m1_gnt, 1);
        tick();
        m1_req = 0;
        #1;
        chk("rlk_pre_m1_rvalid", m1_rvalid, 1);
        reset = 1;
        #1;
        chk("rlk_m1_rvalid_drop", m1_rvalid, 0);
        tick();
        reset = 0;
        m0_req = 1; m0_we = 1; m0_addr = 13'h1F02;
        #1;
        chk("rlk_lock_cleared", m0_gnt, 1);
        chk("rlk_post_m1_rvalid", m1_rvalid, 0);
        tick();
        #1;
        chk("rlk_post2_m1_rvalid", m1_rvalid, 0);
        m1_lock = 0; m0_req = 0; m0_we = 0;

        // asynchronous reset pulse with both requesting and a read outstanding
        tick();
        m0_req = 1; m0_addr = 13'h0001; m1_req = 1; m1_we = 1; m1_addr = 13'h1F03;
        #1;
        chk("rp_m0_gnt", m0_gnt, 1);
        tick();
        #1;
        chk("rp_pre_m0_rvalid", m0_rvalid, 1);
        reset = 1;
        #1;
        chk("rp_m0_gnt", m0_gnt, 0);
        chk("rp_m1_gnt", m1_gnt, 0);
        chk("rp_mem_en", mem_en, 0);
        chk("rp_mem_we", mem_we, 0);
        chk("rp_m0_rvalid", m0_rvalid, 0);
        reset = 0; m0_we = 1;
        tick();
        #1;
        chk("rp_post_m0_rvalid", m0_rvalid, 0);
        chk("rp_post_m1_rvalid", m1_rvalid, 0);
        m0_req = 0; m1_req = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester arbiter sharing one single-port synchronous block RAM in the 6502 test SoC. Port m0 is the 6502 core, which stalls via RDY while it has no grant. Port m1 is the UART debug/loader engine. The block grants one access per cycle, steers the RAM control signals and routes read data back to the issuing port. CPU priority is bounded by a starvation counter, and m1 gets a lock for atomic multi-cycle sequences.

## Interface
Parameters:
- AW, 13, address width
- DW, 8, data width
- MAX_BURST, 4, consecutive m0 grants allowed while m1 waits (1..15)

Ports:
- clk  in  1  system clock (ring-oscillator derived)
- reset  in  1  asynchronous, active-high
- m0_req, m1_req  in  1  access request; held stable until granted
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  address
- m0_wdata, m1_wdata  in  DW  write data
- m1_lock  in  1  m1 holds the RAM exclusively while high, once granted
- m0_gnt, m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  out  1  read data valid (registered)
- m0_rdata, m1_rdata  out  DW  read data, valid only with rvalid
- mem_en, mem_we  out  1  RAM enable / write enable (combinational)
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM output, one cycle after mem_en

## Operation
- State registers:
  - wait_cnt, 4 bits: starvation counter.
  - lock_q: lock ownership.
  - rd_owner, 2 bits: rd_owner[i] = read issued by mi last cycle.
- locked = lock_q & m1_lock.
- Grant decision, combinational, evaluated each cycle:
  - locked: m1_gnt = m1_req; m0_gnt = 0.
  - only one req: grant it.
  - both req, wait_cnt < MAX_BURST: m0 wins.
  - both req, wait_cnt == MAX_BURST: m1 wins.
  - at most one gnt high in any cycle.
- wait_cnt:
  - +1 when m0_gnt & m1_req;
  - cleared when m1_gnt or !m1_req;
  - never exceeds MAX_BURST.
- lock_q <= m1_lock & (lock_q | m1_gnt). Lock takes effect the cycle after the first m1 grant with m1_lock=1. The lock is released in the cycle m1_lock drops, and normal arbitration applies that same cycle.
- mem_en = m0_gnt | m1_gnt. mem_we, mem_addr and mem_wdata are muxed from the granted port. When idle, mem_en=0, mem_we=0 and the other mem_* outputs hold the m0 values.
- rd_owner <= {m1_gnt & !m1_we, m0_gnt & !m0_we}.
- mi_rvalid = rd_owner[i], registered. m0_rdata = m1_rdata = mem_rdata.
- Writes produce no rvalid.
- Reset value of every output: all gnt=0, rvalid=0, mem_en=0, mem_we=0. Internal reset values: wait_cnt=0, lock_q=0, rd_owner=0.
- Combinational gnt and mem_en/mem_we are gated low while reset is high.

## Timing
- Grant latency 0: req in cycle N gives gnt in cycle N, and the RAM samples at the end of cycle N.
- Read data: rvalid and rdata in cycle N+1, for exactly one cycle.
- Throughput: one access per cycle, and back-to-back grants to the same or alternating ports are allowed.
- A requester may change req/addr in the cycle after gnt.
- Starvation bound: with both ports requesting continuously, m1 waits at most MAX_BURST cycles.
- Lock boundaries:
  - m1_lock high with m1_req low while locked: the RAM idles, and m0 stays blocked.
  - m1_lock asserted while m1 is not granted: no effect until m1 is granted.
- Reset asserted mid-read: the rvalid of an outstanding read is dropped and never appears after release.
- First grant possible in the first cycle after reset deasserts.

## Test plan
- Reset: pulse reset asynchronously between edges with both reqs high. Required: all gnt, rvalid and mem_en fall immediately; no rvalid after release.
- m0 alone: write 0x0123<-0xA5, then read 0x0123. Required: gnt in the same cycle each time, m0_rvalid=1 with m0_rdata=0xA5 one cycle after the read grant, m1_rvalid stays 0.
- Both requesting continuously, MAX_BURST=4. Required: grant pattern m0,m0,m0,m0,m1 repeating, wait_cnt never above 4.
- m1 reads 0x0010 with m1_lock=1 for 3 grants while m0_req is high. Required: m0_gnt=0 throughout, and m0 is granted the cycle m1_lock drops (wait_cnt=0).
- Alternating reads: m0 @0x0001 (=0x11), then m1 @0x0002 (=0x22), back-to-back. Required: m0_rvalid with 0x11 in cycle N+1, m1_rvalid with 0x22 in cycle N+2, never both high in one cycle.
- Reset during the cycle after an m1 read grant. Required: m1_rvalid stays 0 and lock_q clears.
